// File: rtl/id_ex_stage_if.sv
// id_ex_stage_if: ID-side inputs, EX-side registered outputs and hazard status of the ID/EX register
interface id_ex_stage_if #(parameter int bits = 32, parameter int cntBits = 16);
  logic id_valid;
  logic [bits-1:0] id_readData1, id_readData2, id_imm;
  logic [4:0] id_rs, id_rt, id_rd;
  logic id_usesRt;
  logic id_regWrite, id_memToReg, id_memRead, id_memWrite, id_aluSrc, id_regDst;
  logic [1:0] id_aluOp;
  logic flush;
  logic stall;
  logic ex_valid;
  logic [bits-1:0] ex_readData1, ex_readData2, ex_imm;
  logic [4:0] ex_rs, ex_rt, ex_rd;
  logic ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_aluSrc, ex_regDst;
  logic [1:0] ex_aluOp;
  logic [cntBits-1:0] bubble_count;
  modport master (
    output id_valid, id_readData1, id_readData2, id_imm, id_rs, id_rt, id_rd, id_usesRt,
           id_regWrite, id_memToReg, id_memRead, id_memWrite, id_aluSrc, id_regDst, id_aluOp, flush,
    input  stall, ex_valid, ex_readData1, ex_readData2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_aluSrc, ex_regDst, ex_aluOp, bubble_count
  );
  modport slave (
    input  id_valid, id_readData1, id_readData2, id_imm, id_rs, id_rt, id_rd, id_usesRt,
           id_regWrite, id_memToReg, id_memRead, id_memWrite, id_aluSrc, id_regDst, id_aluOp, flush,
    output stall, ex_valid, ex_readData1, ex_readData2, ex_imm, ex_rs, ex_rt, ex_rd,
           ex_regWrite, ex_memToReg, ex_memRead, ex_memWrite, ex_aluSrc, ex_regDst, ex_aluOp, bubble_count
  );
endinterface

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use stall, flush bubbles and saturating bubble counter
module id_ex_stage #(parameter int bits = 32, parameter int cntBits = 16) (
  input logic clk,
  input logic reset,
  id_ex_stage_if.slave b
);
  logic bubble;
  // Only registered EX state and live ID inputs feed stall, so flush never loops back into it
  assign b.stall = b.ex_valid & b.ex_memRead & b.id_valid & (b.ex_rt != 5'd0) &
                   ((b.ex_rt == b.id_rs) | (b.id_usesRt & (b.ex_rt == b.id_rt)));
  assign bubble = b.flush | b.stall;
  always_ff @(posedge clk) begin
    if (reset | bubble) begin
      b.ex_valid     <= 1'b0;
      b.ex_readData1 <= {bits{1'b0}};
      b.ex_readData2 <= {bits{1'b0}};
      b.ex_imm       <= {bits{1'b0}};
      b.ex_rs        <= 5'd0;
      b.ex_rt        <= 5'd0;
      b.ex_rd        <= 5'd0;
      b.ex_regWrite  <= 1'b0;
      b.ex_memToReg  <= 1'b0;
      b.ex_memRead   <= 1'b0;
      b.ex_memWrite  <= 1'b0;
      b.ex_aluSrc    <= 1'b0;
      b.ex_regDst    <= 1'b0;
      b.ex_aluOp     <= 2'd0;
    end else begin
      b.ex_valid     <= b.id_valid;
      b.ex_readData1 <= b.id_readData1;
      b.ex_readData2 <= b.id_readData2;
      b.ex_imm       <= b.id_imm;
      b.ex_rs        <= b.id_rs;
      b.ex_rt        <= b.id_rt;
      b.ex_rd        <= b.id_rd;
      b.ex_regWrite  <= b.id_regWrite;
      b.ex_memToReg  <= b.id_memToReg;
      b.ex_memRead   <= b.id_memRead;
      b.ex_memWrite  <= b.id_memWrite;
      b.ex_aluSrc    <= b.id_aluSrc;
      b.ex_regDst    <= b.id_regDst;
      b.ex_aluOp     <= b.id_aluOp;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) b.bubble_count <= {cntBits{1'b0}};
    else if (bubble && b.bubble_count != {cntBits{1'b1}}) b.bubble_count <= b.bubble_count + 1'b1;
  end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of pass-through, load-use stall, flush and counter saturation
module tb_id_ex_stage;
  logic clk = 1'b0;
  logic reset;
  int n_checks = 0;
  int n_errors = 0;
  always #5 clk = ~clk;
  id_ex_stage_if #(.bits(32), .cntBits(4)) b ();
  id_ex_stage #(.bits(32), .cntBits(4)) dut (.clk(clk), .reset(reset), .b(b));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic clear_id();
    b.id_valid = 0; b.id_readData1 = 0; b.id_readData2 = 0; b.id_imm = 0;
    b.id_rs = 0; b.id_rt = 0; b.id_rd = 0; b.id_usesRt = 0;
    b.id_regWrite = 0; b.id_memToReg = 0; b.id_memRead = 0; b.id_memWrite = 0;
    b.id_aluSrc = 0; b.id_regDst = 0; b.id_aluOp = 0; b.flush = 0;
  endtask
  task automatic drive_lw(input logic [4:0] rs, input logic [4:0] rt);
    clear_id();
    b.id_valid = 1; b.id_rs = rs; b.id_rt = rt; b.id_imm = 32'd4;
    b.id_memRead = 1; b.id_memToReg = 1; b.id_regWrite = 1; b.id_aluSrc = 1;
  endtask
  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd, input logic uses_rt);
    clear_id();
    b.id_valid = 1; b.id_rs = rs; b.id_rt = rt; b.id_rd = rd; b.id_usesRt = uses_rt;
    b.id_regWrite = 1; b.id_regDst = 1; b.id_aluOp = 2'd2;
  endtask
  initial begin
    clear_id();
    reset = 1;
    tick();
    tick();
    reset = 0;
    check("rst_ex_valid", b.ex_valid, 0);
    check("rst_count", b.bubble_count, 0);
    check("rst_stall", b.stall, 0);
    check("rst_rd1", b.ex_readData1, 0);
    // pass-through
    clear_id();
    b.id_valid = 1; b.id_readData1 = 32'h11; b.id_readData2 = 32'h22; b.id_imm = 32'hFFFF_FFF0;
    b.id_aluSrc = 1; b.id_regWrite = 1; b.id_rs = 1; b.id_rt = 2; b.id_rd = 3; b.id_aluOp = 2'd1;
    tick();
    check("pt_valid", b.ex_valid, 1);
    check("pt_rd1", b.ex_readData1, 32'h11);
    check("pt_rd2", b.ex_readData2, 32'h22);
    check("pt_imm", b.ex_imm, 32'hFFFF_FFF0);
    check("pt_alusrc", b.ex_aluSrc, 1);
    check("pt_regwrite", b.ex_regWrite, 1);
    check("pt_spec", {b.ex_rs, b.ex_rt, b.ex_rd}, {5'd1, 5'd2, 5'd3});
    check("pt_aluop", b.ex_aluOp, 1);
    check("pt_memread", b.ex_memRead, 0);
    check("pt_stall", b.stall, 0);
    check("pt_count", b.bubble_count, 0);
    // load-use on rs
    drive_lw(5'd4, 5'd8);
    tick();
    check("lu_ex_memread", b.ex_memRead, 1);
    drive_add(5'd8, 5'd5, 5'd10, 1'b1);
    #1;
    check("lu_stall", b.stall, 1);
    tick();
    check("lu_bub_valid", b.ex_valid, 0);
    check("lu_bub_rs", b.ex_rs, 0);
    check("lu_bub_regwrite", b.ex_regWrite, 0);
    check("lu_bub_regdst", b.ex_regDst, 0);
    check("lu_stall_off", b.stall, 0);
    check("lu_count", b.bubble_count, 1);
    tick();
    check("lu_add_valid", b.ex_valid, 1);
    check("lu_add_rs", b.ex_rs, 8);
    check("lu_add_rd", b.ex_rd, 10);
    check("lu_add_regdst", b.ex_regDst, 1);
    check("lu_add_count", b.bubble_count, 1);
    // rt-only dependency gated by usesRt
    drive_lw(5'd0, 5'd9);
    tick();
    drive_add(5'd3, 5'd9, 5'd11, 1'b0);
    #1;
    check("rt_nouse_stall", b.stall, 0);
    b.id_usesRt = 1;
    #1;
    check("rt_use_stall", b.stall, 1);
    tick();
    check("rt_count", b.bubble_count, 2);
    check("rt_stall_off", b.stall, 0);
    tick();
    check("rt_held_rt", b.ex_rt, 9);
    // $zero load never stalls
    drive_lw(5'd1, 5'd0);
    tick();
    check("z_ex_memread", b.ex_memRead, 1);
    drive_add(5'd0, 5'd0, 5'd12, 1'b1);
    #1;
    check("z_stall", b.stall, 0);
    // flush of a valid instruction
    b.flush = 1;
    tick();
    b.flush = 0;
    check("fl_valid", b.ex_valid, 0);
    check("fl_regwrite", b.ex_regWrite, 0);
    check("fl_rd", b.ex_rd, 0);
    check("fl_count", b.bubble_count, 3);
    // flush and stall together count once
    drive_lw(5'd1, 5'd7);
    tick();
    drive_add(5'd7, 5'd2, 5'd13, 1'b1);
    #1;
    check("fs_stall", b.stall, 1);
    b.flush = 1;
    tick();
    b.flush = 0;
    check("fs_count", b.bubble_count, 4);
    check("fs_valid", b.ex_valid, 0);
    // reset during an active stall
    drive_lw(5'd1, 5'd6);
    tick();
    drive_add(5'd6, 5'd2, 5'd14, 1'b1);
    #1;
    check("rs_stall_pre", b.stall, 1);
    reset = 1;
    tick();
    reset = 0;
    check("rs_valid", b.ex_valid, 0);
    check("rs_memread", b.ex_memRead, 0);
    check("rs_count", b.bubble_count, 0);
    check("rs_stall", b.stall, 0);
    // invalid ID slot is captured, not counted
    clear_id();
    b.id_readData1 = 32'hAB;
    tick();
    check("iv_valid", b.ex_valid, 0);
    check("iv_rd1", b.ex_readData1, 32'hAB);
    check("iv_count", b.bubble_count, 0);
    // saturation at 15
    b.flush = 1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", b.bubble_count, 14);
    tick();
    check("sat_15", b.bubble_count, 15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold", b.bubble_count, 15);
    b.flush = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
